// File: rtl/riscv_data_mem_responder.sv
// Data-bus memory responder: one load/store at a time, fixed-latency response.
// Ports: i_clk/i_rst (async, active-high); request channel i_req_valid/o_req_ready,
//   i_req_we, i_req_addr (byte address), i_req_wdata, i_req_wstrb;
//   response channel o_rsp_valid/i_rsp_ready, o_rsp_rdata, o_rsp_err.
module riscv_data_mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [3:0]  i_req_wstrb,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t state;
    state_t next_state;

    logic [3:0]  cnt;
    logic        cap_we;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_wstrb;

    logic        accept;
    logic        enter_resp;

    logic        acc_we;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [3:0]  acc_wstrb;
    logic        acc_err;
    logic [ADDR_WIDTH-1:0] idx;

    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem [2**ADDR_WIDTH];

    assign accept = i_req_valid && (state == IDLE);

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        enter_resp = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        next_state = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd1) begin
                    next_state = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                if (i_rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        o_req_ready = (state == IDLE);
        o_rsp_valid = (state == RESP);
        o_rsp_rdata = rdata_q;
        o_rsp_err   = err_q;
    end

    // With LATENCY==1 the RAM is accessed at the acceptance edge itself,
    // before the capture registers hold the request, so use the live inputs.
    always_comb begin
        if (state == IDLE) begin
            acc_we    = i_req_we;
            acc_addr  = i_req_addr;
            acc_wdata = i_req_wdata;
            acc_wstrb = i_req_wstrb;
        end else begin
            acc_we    = cap_we;
            acc_addr  = cap_addr;
            acc_wdata = cap_wdata;
            acc_wstrb = cap_wstrb;
        end
    end

    // Any address bit above the RAM index makes the request out of range.
    assign acc_err = (|acc_addr[1:0]) | (|(acc_addr[31:2] >> ADDR_WIDTH));
    assign idx     = acc_addr[ADDR_WIDTH+1:2];

    // RAM is not reset; a reset edge must never commit a pending store.
    always_ff @(posedge i_clk) begin
        if (enter_resp && !i_rst && acc_we && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_wstrb[b]) begin
                    mem[idx][8*b +: 8] <= acc_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt       <= '0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_wstrb <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            if (accept) begin
                cap_we    <= i_req_we;
                cap_addr  <= i_req_addr;
                cap_wdata <= i_req_wdata;
                cap_wstrb <= i_req_wstrb;
                cnt       <= CNT_INIT;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end

            if (enter_resp) begin
                err_q   <= acc_err;
                rdata_q <= (!acc_we && !acc_err) ? mem[idx] : 32'd0;
            end else if (state == RESP && i_rsp_ready) begin
                err_q   <= 1'b0;
                rdata_q <= 32'd0;
            end
        end
    end

endmodule
